// File: rtl/spike_detect_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spike_detect_fifo
// Purpose  : Per-channel threshold spike detector for two 32-channel banks,
//            with a per-channel refractory period and a dual-push event FIFO.
//            Define SPIKE_BIPOLAR_EN to also detect positive excursions.
// Revision : 1.0 - initial release
// ============================================================================
module spike_detect_fifo #(
  parameter int          REFRACT    = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MEDIAN     = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  thr_wr_valid,
  input  logic [15:0] thr_wr_data,
  input  logic [7:0]  thr_wr_addr,
  input  logic        raw_data_valid0,
  input  logic        raw_data_valid1,
  input  logic [15:0] raw_data0,
  input  logic [15:0] raw_data1,
  input  logic [6:0]  channel,
  input  logic        det_en,
  input  logic        clr,
  output logic        ev_valid,
  output logic [15:0] ev_data,
  input  logic        ev_ready,
  output logic        ev_overflow,
  output logic [6:0]  ev_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  logic             w_ch_ok;
  logic [4:0]       w_ch;
  logic             w_ts_inc;
  logic [7:0]       r_ts;
  logic [7:0]       w_ts_next;
  logic [4:0]       r_s1_ch;
  logic [7:0]       r_s1_ts;
  logic             r_s1_det;
  logic [1:0]       w_raw_vld;
  logic [1:0]       w_s2_spike;
  logic [1:0][15:0] w_s2_word;

  assign w_ch_ok   = (channel[6:5] == 2'b00);
  assign w_ch      = channel[4:0];
  assign w_ts_inc  = raw_data_valid0 && (channel == 7'd0);
  assign w_ts_next = w_ts_inc ? r_ts + 8'd1 : r_ts;
  assign w_raw_vld = {raw_data_valid1, raw_data_valid0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts     <= '0;
      r_s1_ch  <= '0;
      r_s1_ts  <= '0;
      r_s1_det <= 1'b0;
    end else if (clr) begin
      r_ts     <= '0;
      r_s1_ch  <= '0;
      r_s1_ts  <= '0;
      r_s1_det <= 1'b0;
    end else begin
      r_ts     <= w_ts_next;
      r_s1_ch  <= w_ch;
      r_s1_ts  <= w_ts_next;
      r_s1_det <= det_en;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [15:0]        w_raw;
    logic [5:0]         w_ch6;
    logic [15:0]        r_thr [32];
    logic [5:0]         r_ref [32];
    logic               r_s1_v;
    logic [15:0]        r_s1_raw;
    logic [15:0]        r_s1_thr;
    logic [5:0]         r_s1_ref;
    logic signed [16:0] w_dev_neg;
    logic               w_neg;
    logic               w_pos;
    logic               w_hit;
    logic [5:0]         w_ref_upd;
    logic [15:0]        w_word;
    logic               r_s2_spike;
    logic [15:0]        r_s2_word;

    assign w_raw = (b == 0) ? raw_data0 : raw_data1;
    assign w_ch6 = {(b == 1), r_s1_ch};

    assign w_dev_neg = $signed({1'b0, MEDIAN}) - $signed({1'b0, r_s1_raw});
    assign w_neg     = (w_dev_neg > 17'sd0) && (w_dev_neg > $signed({1'b0, r_s1_thr}));

`ifdef SPIKE_BIPOLAR_EN
    logic signed [16:0] w_dev_pos;
    assign w_dev_pos = $signed({1'b0, r_s1_raw}) - $signed({1'b0, MEDIAN});
    assign w_pos     = (w_dev_pos > 17'sd0) && (w_dev_pos > $signed({1'b0, r_s1_thr}));
    assign w_word    = {1'b1, w_pos, w_ch6, r_s1_ts};
`else
    assign w_pos  = 1'b0;
    assign w_word = {2'b10, w_ch6, r_s1_ts};
`endif

    assign w_hit = r_s1_v && r_s1_det && (r_s1_thr != 16'd0) &&
                   (r_s1_ref == 6'd0) && (w_neg || w_pos);

    // Counts only run down while detection is enabled for this sample
    assign w_ref_upd = w_hit ? 6'(REFRACT) :
                       (r_s1_det && (r_s1_ref != 6'd0)) ? r_s1_ref - 6'd1 : r_s1_ref;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) r_thr[i] <= '0;
      end else if (thr_wr_valid[b] && (thr_wr_addr[7:5] == 3'd0)) begin
        r_thr[thr_wr_addr[4:0]] <= thr_wr_data;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) r_ref[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < 32; i++) r_ref[i] <= '0;
      end else if (r_s1_v) begin
        r_ref[r_s1_ch] <= w_ref_upd;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_v     <= 1'b0;
        r_s1_raw   <= '0;
        r_s1_thr   <= '0;
        r_s1_ref   <= '0;
        r_s2_spike <= 1'b0;
        r_s2_word  <= '0;
      end else if (clr) begin
        r_s1_v     <= 1'b0;
        r_s1_raw   <= '0;
        r_s1_thr   <= '0;
        r_s1_ref   <= '0;
        r_s2_spike <= 1'b0;
        r_s2_word  <= '0;
      end else begin
        r_s1_v     <= w_raw_vld[b] && w_ch_ok;
        r_s1_raw   <= w_raw;
        r_s1_thr   <= r_thr[w_ch];
        // Forward the count being written back so back-to-back samples of a channel see it
        r_s1_ref   <= (r_s1_v && (r_s1_ch == w_ch)) ? w_ref_upd : r_ref[w_ch];
        r_s2_spike <= w_hit;
        r_s2_word  <= w_word;
      end
    end

    assign w_s2_spike[b] = r_s2_spike;
    assign w_s2_word[b]  = r_s2_word;
  end

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [6:0]      r_count;
  logic            r_overflow;
  logic            w_pop;
  logic [6:0]      w_free;
  logic            w_push0;
  logic            w_push1;
  logic            w_drop;

  assign w_pop   = (r_count != 7'd0) && ev_ready;
  // Slot freed by a same-cycle pop is available to the push
  assign w_free  = 7'(FIFO_DEPTH) - r_count + {6'd0, w_pop};
  assign w_push0 = w_s2_spike[0] && (w_free != 7'd0);
  assign w_push1 = w_s2_spike[1] && (w_free > {6'd0, w_push0});
  assign w_drop  = (w_s2_spike[0] && !w_push0) || (w_s2_spike[1] && !w_push1);

  always_ff @(posedge clk) begin
    if (w_push0) r_mem[r_wr_ptr] <= w_s2_word[0];
    if (w_push1) r_mem[r_wr_ptr + {{(c_AW-1){1'b0}}, w_push0}] <= w_s2_word[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + {{(c_AW-1){1'b0}}, w_push0} + {{(c_AW-1){1'b0}}, w_push1};
      r_rd_ptr   <= r_rd_ptr + {{(c_AW-1){1'b0}}, w_pop};
      r_count    <= r_count + {6'd0, w_push0} + {6'd0, w_push1} - {6'd0, w_pop};
      r_overflow <= r_overflow || w_drop;
    end
  end

  assign ev_valid    = (r_count != 7'd0);
  assign ev_data     = ev_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign ev_overflow = r_overflow;
  assign ev_count    = r_count;

endmodule
`default_nettype wire

// File: doc/spike_detect_fifo.md
Name: spike_detect_fifo

Overview:
- Downstream consumer of the threshold calculation controller's per-channel thresholds.
- Latches 64 thresholds: bank 0 = channels 0-31, bank 1 = channels 32-63.
- Compares every incoming raw sample against its channel threshold and applies a per-channel refractory period.
- Queues spike event words in a small FIFO for the uplink packetiser.

Parameters:
- REFRACT, 32, samples of the same channel suppressed after a detection (1..63).
- FIFO_DEPTH, 16, event FIFO entries (power of 2, 4..64).
- MEDIAN, 16'h8000, offset-binary zero level of raw samples.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- thr_wr_valid  in  2  bit0 writes bank 0, bit1 writes bank 1; both may be high
- thr_wr_data  in  16  threshold value written to the addressed channel
- thr_wr_addr  in  8  within-bank channel index; only 0..31 are valid
- raw_data_valid0  in  1  bank 0 sample valid
- raw_data_valid1  in  1  bank 1 sample valid
- raw_data0  in  16  bank 0 sample
- raw_data1  in  16  bank 1 sample
- channel  in  7  within-bank index of the current samples; only 0..31 are valid
- det_en  in  1  detection enable; tie to ~cal_busy
- clr  in  1  synchronous clear of FIFO, refractory counters and overflow flag; thresholds are kept
- ev_valid  out  1  event word available
- ev_data  out  16  event word {2'b10, ch[5:0], ts[7:0]}
- ev_ready  in  1  consumer accepts the event word
- ev_overflow  out  1  sticky flag: an event was dropped
- ev_count  out  7  current FIFO occupancy

Behaviour:
- Reset and clr:
  - Reset clears thresholds, refractory counters, ts, FIFO, ev_valid, ev_data and ev_overflow to 0.
  - clr clears the same state except thresholds.
- Threshold of 0 disables detection on that channel.
- Threshold writes:
  - Writes with thr_wr_addr > 31 are ignored.
  - A write takes effect for samples entering stage 1 on the next cycle.
- Timestamp:
  - ts is an 8-bit counter; it increments when raw_data_valid0 is high with channel==0 and wraps 255 -> 0.
  - ts increments before that sample's compare, so the channel-0 sample carries the new value.
- Pipeline:
  - Stage 1 registers the sample, channel, ts, and the threshold and refractory count of both banks.
  - Stage 2 compares, updates the refractory count and pushes the event.
- Compare:
  - dev = MEDIAN - raw, computed as a 17-bit signed value.
  - Spike when all hold: dev > 0, dev > thr, refractory==0, det_en high (sampled at stage 1), channel <= 31.
- Refractory:
  - On a spike the channel's count loads REFRACT.
  - Otherwise each valid sample of a channel with a nonzero count decrements it by 1.
  - Samples for channel > 31 are ignored: no state change and no ts change.
- Latency: sample valid at cycle N -> ev_valid high at N+3 when the FIFO was empty; ev_data is FWFT.
- Channel numbering: bank 0 events carry ch = channel; bank 1 events carry ch = channel+32.
- Simultaneous bank spikes:
  - Both events are pushed in the same cycle, bank 0 first.
  - If only one slot is free, bank 0 is stored, bank 1 is dropped and ev_overflow is set.
  - If the FIFO is full, both are dropped and ev_overflow is set.
- Pop:
  - ev_valid && ev_ready pops one entry.
  - A pop and push in the same cycle on a full FIFO is allowed: the freed slot is counted before the push.
- det_en falling mid-stream:
  - Samples already in stage 1 are still evaluated with their captured enable.
  - Refractory counts freeze while det_en is low.

Optional Feature:
- Macro: SPIKE_BIPOLAR_EN.
- Defined: a spike also occurs when raw - MEDIAN > thr (positive excursion).
  - The event word becomes {1'b1, pol, ch[5:0], ts[7:0]}, with pol=1 for positive.
- Undefined: negative-only detection, using the word format given under Ports.

Test Plan:
- Write thr=0x0100 to bank 0 ch5; feed ch5 raw=0x7E00 -> one event 0x8500|ts after 3 cycles; raw=0x7F00 (dev = thr) -> no event.
- Spike on ch5, then 40 further ch5 samples all at 0x7000 with REFRACT=32 -> first event, next event on the 33rd subsequent sample.
- Bank 0 ch3 and bank 1 ch3 both spike in the same cycle -> ev_data 0x83xx then 0xA3xx (channel 35), both with the same ts.
- Hold ev_ready=0 and generate 18 spikes with FIFO_DEPTH=16 -> ev_count=16, ev_overflow=1; drain -> first 16 events in order; clr -> ev_overflow=0.
- det_en=0 with spiking data -> no events; thr=0 on a channel with det_en=1 -> no events; assert rst while 5 entries are queued -> ev_valid=0 and ev_count=0 immediately.
- With SPIKE_BIPOLAR_EN defined: raw=0x8200, thr=0x0100 -> event with pol=1; without the macro -> no event.
